// File: rtl/spi_arb_pkg.sv
// Shared state encoding, word/counter widths and index helper for the SPI transaction arbiter.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   localparam int unsigned SPI_WORD_W = 12;
   localparam int unsigned TIMEOUT_W  = 16;

   // Width of a requester index; never zero so a 1-bit pointer still exists.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin encoder: first asserted req at or after rr_ptr, wrapping.
module spi_rr_picker
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IW      = idx_w(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      rr_ptr,
   output logic               valid,
   output logic [IW-1:0]      index
);

   int unsigned pos;

   always_comb begin
      valid = 1'b0;
      index = '0;
      pos   = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pos = (32'(rr_ptr) + i) % NUM_REQ;
         if (!valid && req[IW'(pos)]) begin
            valid = 1'b1;
            index = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_REQ clients.
// Define SPI_ARB_TIMEOUT_EN to build the ISSUE-state timeout and sticky err flag.
module spi_txn_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = SPI_WORD_W,
   parameter int unsigned TIMEOUT = 4096
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      busy,
   output logic                      newd,
   output logic [DATA_W-1:0]         din,
   input  logic                      cs,
   output logic                      err
);

   localparam int unsigned IW = idx_w(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W != SPI_WORD_W ||
       TIMEOUT < 2 || TIMEOUT > (1 << TIMEOUT_W)) begin : g_cfg_check
      $error("spi_txn_arbiter: unsupported parameter set");
   end

   arb_state_e          state;
   logic                cs_m;
   logic                cs_s;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       cur;
   logic [IW-1:0]       next_ptr;
   logic                pick_valid;
   logic [IW-1:0]       pick_idx;
   logic [NUM_REQ-1:0]  pick_oh;

   spi_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr),
      .valid  (pick_valid),
      .index  (pick_idx)
   );

   always_comb begin
      pick_oh           = '0;
      pick_oh[pick_idx] = 1'b1;
      next_ptr          = (32'(cur) == NUM_REQ - 1) ? '0 : cur + 1'b1;
   end

   // cs comes from the sclk domain logic of spi_master; treat it as asynchronous.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cs_m <= 1'b1;
         cs_s <= 1'b1;
      end else begin
         cs_m <= cs;
         cs_s <= cs_m;
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);
   logic [TIMEOUT_W-1:0] to_cnt;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         gnt    <= '0;
         ack    <= '0;
         busy   <= 1'b0;
         newd   <= 1'b0;
         din    <= '0;
         rr_ptr <= '0;
         cur    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         to_cnt <= '0;
         err    <= 1'b0;
`endif
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt   <= pick_oh;
                  cur   <= pick_idx;
                  din   <= req_data[pick_idx*DATA_W +: DATA_W];
                  newd  <= 1'b1;
                  busy  <= 1'b1;
                  state <= ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
                  to_cnt <= '0;
`endif
               end
            end
            ISSUE: begin
               if (!cs_s) begin
                  newd  <= 1'b0;
                  state <= XFER;
               end
`ifdef SPI_ARB_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  // Master never started the frame: release it and still ack the client.
                  newd  <= 1'b0;
                  err   <= 1'b1;
                  ack   <= gnt;
                  state <= DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            XFER: begin
               if (cs_s) begin
                  ack   <= gnt;
                  state <= DONE;
               end
            end
            DONE: begin
               gnt    <= '0;
               busy   <= 1'b0;
               rr_ptr <= next_ptr;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SPI_ARB_TIMEOUT_EN
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized scoreboard bench for spi_txn_arbiter with a behavioural spi_master stand-in.
module tb_spi_txn_arbiter;

   localparam int N  = 4;
   localparam int W  = 12;
   localparam int TO = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic           busy;
   logic           newd;
   logic [W-1:0]   din;
   logic           cs;
   logic           err;

   always #5 clk = ~clk;

   spi_txn_arbiter #(
      .NUM_REQ (N),
      .DATA_W  (W),
      .TIMEOUT (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .ack      (ack),
      .busy     (busy),
      .newd     (newd),
      .din      (din),
      .cs       (cs),
      .err      (err)
   );

   typedef struct {
      int           idx;
      logic [W-1:0] word;
   } exp_t;

   int           checks   = 0;
   int           failures = 0;
   exp_t         exp_q[$];
   logic [W-1:0] rx_q[$];
   exp_t         cur;
   bit           cur_v;
   bit           spi_en;
   int           model_ptr;
   int           run_len;
   int           last_len;
   int           cnt[N];
   logic [W-1:0] words[N][2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // spi_master stand-in: frames start 1..4 clk after newd, one bit every 2 clk.
   initial begin
      logic [W-1:0] rx;
      bit           ab;
      cs = 1'b1;
      forever begin
         @(negedge clk);
         if (rst && spi_en && newd) begin
            ab = 1'b0;
            rx = '0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            cs = 1'b0;
            for (int b = W - 1; b >= 0 && !ab; b--) begin
               rx[b] = din[b];
               repeat (2) begin
                  @(negedge clk);
                  if (!rst) ab = 1'b1;
               end
            end
            cs = 1'b1;
            if (!ab) rx_q.push_back(rx);
         end
      end
   end

   // Monitor: pops the scoreboard on each grant and checks every ack.
   initial begin
      bit prev_newd;
      bit after_ack;
      prev_newd = 1'b0;
      after_ack = 1'b0;
      cur_v     = 1'b0;
      run_len   = 0;
      last_len  = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_newd = 1'b0;
            after_ack = 1'b0;
            cur_v     = 1'b0;
            run_len   = 0;
         end else begin
            check("gnt_onehot0", 32'($countones(gnt) <= 1), 1);
            if (after_ack) begin
               check("busy_after_ack", busy, 0);
               check("gnt_after_ack", gnt, 0);
               after_ack = 1'b0;
            end
            if (newd && !prev_newd) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_grant: got gnt=%0h expected no grant", gnt);
               end else begin
                  cur   = exp_q.pop_front();
                  cur_v = 1'b1;
                  check("grant", gnt, 32'd1 << cur.idx);
                  check("din", din, cur.word);
                  check("busy", busy, 1);
               end
            end
            if (newd) run_len++;
            else if (prev_newd) begin
               last_len = run_len;
               run_len  = 0;
            end
            if (ack != '0) begin
               if (!cur_v) begin
                  checks++;
                  failures++;
                  $display("FAIL spurious_ack: got ack=%0h expected none", ack);
               end else begin
                  check("ack", ack, 32'd1 << cur.idx);
                  check("gnt_at_ack", gnt, 32'd1 << cur.idx);
                  if (spi_en) begin
                     if (rx_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_missing: got no frame expected %0h", cur.word);
                     end else begin
                        check("rx_word", rx_q.pop_front(), cur.word);
                     end
                  end
                  cur_v     = 1'b0;
                  after_ack = 1'b1;
               end
            end
            prev_newd = newd;
         end
      end
   end

   // Requesters in mask all raise req together; requester i sends cnt[i] words and
   // holds req until its last ack. Expected order follows the round-robin rule.
   task automatic run_batch(input logic [N-1:0] mask, input logic [N-1:0] dmask, input bit chk_lat);
      int left[N];
      int exp_n[N];
      int sent[N];
      int acks[N];
      int ptr;
      int total;
      int got;
      int budget;
      bit any;
      ptr   = model_ptr;
      total = 0;
      for (int i = 0; i < N; i++) begin
         left[i]  = mask[i] ? cnt[i] : 0;
         exp_n[i] = left[i];
         sent[i]  = 0;
         acks[i]  = 0;
         total   += left[i];
      end
      any = (total > 0);
      while (any) begin
         for (int o = 0; o < N; o++) begin
            int k;
            k = (ptr + o) % N;
            if (left[k] > 0) begin
               exp_q.push_back('{k, words[k][cnt[k] - left[k]]});
               left[k]--;
               ptr = (k + 1) % N;
               break;
            end
         end
         any = 1'b0;
         for (int i = 0; i < N; i++) if (left[i] > 0) any = 1'b1;
      end
      model_ptr = ptr;

      for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i][0];
      req = mask;
      if (chk_lat) begin
         @(negedge clk);
         check("latency_newd", newd, 1);
      end
      got    = 0;
      budget = 0;
      while (got < total && budget < 3000) begin
         @(negedge clk);
         budget++;
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               acks[i]++;
               got++;
               sent[i]++;
               if (sent[i] >= cnt[i]) req[i] = 1'b0;
               else req_data[i*W +: W] = words[i][sent[i]];
            end else if (dmask[i] && req[i] && !cs && gnt[i] && sent[i] == cnt[i] - 1) begin
               req[i] = 1'b0;
            end
         end
      end
      if (got < total) begin
         checks++;
         failures++;
         $display("FAIL batch_timeout: got %0d acks expected %0d", got, total);
      end
      req = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) check("ack_count", acks[i], exp_n[i]);
      check("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      req       = '1;
      req_data  = '0;
      spi_en    = 1'b1;
      model_ptr = 0;

      repeat (3) begin
         @(negedge clk);
         check("rst_gnt", gnt, 0);
         check("rst_ack", ack, 0);
         check("rst_newd", newd, 0);
         check("rst_busy", busy, 0);
         check("rst_err", err, 0);
      end
      req = '0;
      rst = 1'b1;
      @(negedge clk);

      // Fairness with all four held: order 0,1,2,3,0.
      cnt = '{2, 1, 1, 1};
      words[0][0] = 12'h111; words[0][1] = 12'h111;
      words[1][0] = 12'h222; words[2][0] = 12'h333; words[3][0] = 12'h444;
      run_batch(4'hF, 4'h0, 1'b0);

      cnt = '{1, 1, 1, 1};
      words[2][0] = 12'hA5C;
      run_batch(4'b0100, 4'h0, 1'b1);

      words[1][0] = 12'h3C6;
      run_batch(4'b0010, 4'b0010, 1'b0);

      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] m;
         logic [N-1:0] dm;
         m  = 4'($urandom_range(1, 15));
         dm = 4'($urandom_range(0, 15)) & m;
         for (int i = 0; i < N; i++) begin
            cnt[i]      = $urandom_range(1, 2);
            words[i][0] = 12'($urandom);
            words[i][1] = 12'($urandom);
         end
         run_batch(m, dm, 1'b0);
      end
      check("err_clear", err, 0);

      // Abort a frame mid-transfer with rr_ptr away from 0.
      cnt = '{1, 1, 1, 1};
      words[1][0] = 12'h5A5;
      run_batch(4'b0010, 4'h0, 1'b0);
      begin
         int b;
         exp_q.push_back('{2, 12'h777});
         req_data[2*W +: W] = 12'h777;
         req = 4'b0100;
         b = 0;
         while (cs && b < 200) begin
            @(negedge clk);
            b++;
         end
         check("abort_cs_low", cs, 0);
         repeat (4) @(negedge clk);
         rst = 1'b0;
         req = '0;
         @(negedge clk);
         check("abort_gnt", gnt, 0);
         check("abort_ack", ack, 0);
         check("abort_newd", newd, 0);
         check("abort_busy", busy, 0);
         check("abort_din", din, 0);
         @(negedge clk);
         rst = 1'b1;
         exp_q.delete();
         rx_q.delete();
         model_ptr = 0;
      end
      repeat (30) @(negedge clk);
      words[0][0] = 12'h0A1; words[3][0] = 12'h0D4;
      run_batch(4'b1001, 4'h0, 1'b0);
      words[0][0] = 12'h001;
      run_batch(4'b0001, 4'h0, 1'b1);

      // Master never answers: cs stays high.
      spi_en = 1'b0;
      words[1][0] = 12'h0F0;
`ifdef SPI_ARB_TIMEOUT_EN
      run_batch(4'b0010, 4'h0, 1'b0);
      check("timeout_newd_len", last_len, TO);
      check("timeout_err", err, 1);
      check("timeout_busy", busy, 0);
`else
      exp_q.push_back('{1, 12'h0F0});
      req_data[W +: W] = 12'h0F0;
      req = 4'b0010;
      repeat (100) @(negedge clk);
      check("stuck_newd", newd, 1);
      check("stuck_busy", busy, 1);
      check("stuck_gnt", gnt, 4'b0010);
      check("stuck_err", err, 0);
      rst = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
